// File: rtl/pad_pkg.sv
// pad_pkg: shared definitions for the Mega Drive pad scanner.
//   - button bit positions inside the 12-bit button vector
//   - pad pin positions inside the 7-bit port bus
//   - scanner state encoding and the idle tap-selector value
package pad_pkg;

    // Button vector bit positions (active-high in btn_t).
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_Z     = 10;
    localparam int BTN_MODE  = 11;

    // Pad pin positions on the port bus (pins are active low).
    localparam int PIN_D0 = 0;
    localparam int PIN_D1 = 1;
    localparam int PIN_D2 = 2;
    localparam int PIN_D3 = 3;
    localparam int PIN_TL = 4;
    localparam int PIN_TR = 5;
    localparam int PIN_TH = 6;

    typedef logic [11:0] btn_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL   = 2'd1,
        PHASE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Tap selector with the enable (bit 6) high: no player selected.
    localparam logic [6:0] TAP_NONE = 7'h70;

    // Selector value for a player: enable low, index on [5:4].
    function automatic logic [6:0] tap_select(input logic multi, input logic [1:0] idx);
        return multi ? {1'b0, idx, 4'h0} : TAP_NONE;
    endfunction

endpackage

// File: rtl/pad_scanner_if.sv
// pad_scanner_if: physical pad-port bundle between the scanner and the pins.
//   port_in  : pad pins as seen by the console ([3:0] D0-D3, [4] TL, [5] TR, [6] TH readback)
//   port_out : values driven onto the pad pins (only TH, bit 6, is meaningful)
//   port_dir : per-pin output enable, 1 = driven
//   tap_out  : 4-way tap selector lines on the second port
// Modports: master = scanner side, slave = pad/pin side.
interface pad_scanner_if;

    logic [6:0] port_in;
    logic [6:0] port_out;
    logic [6:0] port_dir;
    logic [6:0] tap_out;

    modport master (
        input  port_in,
        output port_out,
        output port_dir,
        output tap_out
    );

    modport slave (
        output port_in,
        input  port_out,
        input  port_dir,
        input  tap_out
    );

endinterface

// File: rtl/pad_phase_decode.sv
// pad_phase_decode: combinational decode of one sampled pad-pin set for a
// given handshake phase. Produces a per-bit update mask and value for the
// button vector plus write enables/values for the present and six flags.
// Ports:
//   phase       : handshake phase 0..7 the sample belongs to
//   pins        : sampled D0-D3/TL/TR (active low)
//   present_in  : present flag accumulated so far for this player
//   six_in      : six-button flag accumulated so far for this player
//   btn_mask    : 1 = this button bit is updated by this phase
//   btn_val     : new value for masked button bits (active high)
//   present_we / present_val, six_we / six_val : flag updates
module pad_phase_decode
    import pad_pkg::*;
(
    input  logic [2:0] phase,
    input  logic [5:0] pins,
    input  logic       present_in,
    input  logic       six_in,
    output btn_t       btn_mask,
    output btn_t       btn_val,
    output logic       present_we,
    output logic       present_val,
    output logic       six_we,
    output logic       six_val
);

    always_comb begin
        btn_mask    = '0;
        btn_val     = '0;
        present_we  = 1'b0;
        present_val = 1'b0;
        six_we      = 1'b0;
        six_val     = 1'b0;
        case (phase)
            3'd0: begin
                // TH high: directions plus B/C.
                btn_mask[BTN_UP]    = 1'b1;
                btn_mask[BTN_DOWN]  = 1'b1;
                btn_mask[BTN_LEFT]  = 1'b1;
                btn_mask[BTN_RIGHT] = 1'b1;
                btn_mask[BTN_B]     = 1'b1;
                btn_mask[BTN_C]     = 1'b1;
                btn_val[BTN_UP]     = ~pins[PIN_D0];
                btn_val[BTN_DOWN]   = ~pins[PIN_D1];
                btn_val[BTN_LEFT]   = ~pins[PIN_D2];
                btn_val[BTN_RIGHT]  = ~pins[PIN_D3];
                btn_val[BTN_B]      = ~pins[PIN_TL];
                btn_val[BTN_C]      = ~pins[PIN_TR];
            end
            3'd1: begin
                // TH low: a pad pulls D2/D3 low; open pins float high.
                present_we          = 1'b1;
                present_val         = (pins[PIN_D3:PIN_D2] == 2'b00);
                btn_mask[BTN_A]     = 1'b1;
                btn_mask[BTN_START] = 1'b1;
                btn_val[BTN_A]      = ~pins[PIN_TL];
                btn_val[BTN_START]  = ~pins[PIN_TR];
            end
            3'd5: begin
                // Third TH low: a 6-button pad drives all of D0-D3 low.
                six_we  = 1'b1;
                six_val = (pins[PIN_D3:PIN_D0] == 4'b0000) && present_in;
            end
            3'd6: begin
                // Extra buttons; forced clear for 3-button pads so stale
                // upper bits can never leak through.
                btn_mask[BTN_X]    = 1'b1;
                btn_mask[BTN_Y]    = 1'b1;
                btn_mask[BTN_Z]    = 1'b1;
                btn_mask[BTN_MODE] = 1'b1;
                if (six_in) begin
                    btn_val[BTN_Z]    = ~pins[PIN_D0];
                    btn_val[BTN_Y]    = ~pins[PIN_D1];
                    btn_val[BTN_X]    = ~pins[PIN_D2];
                    btn_val[BTN_MODE] = ~pins[PIN_D3];
                end
            end
            default: begin
                // Phases 2, 3, 4 and 7 carry nothing new.
            end
        endcase
    end

endmodule

// File: rtl/pad_scanner.sv
// pad_scanner: console-side Mega Drive pad reader.
// Walks TH through the 8-phase 3/6-button handshake, optionally stepping a
// 4-way tap through four players, and publishes all results at once.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   multitap         : 1 = scan 4 players through the tap (sampled at scan start)
//   pad              : pad pin bundle (port_in/port_out/port_dir/tap_out)
//   p1_btn..p4_btn   : active-high button vectors per player
//   present, six_btn : per-player pad detected / 6-button pad detected
//   valid            : 1-cycle pulse when all result outputs were updated
//   dbg_state        : current FSM state (IDLE/SEL/PHASE/DONE encoding)
module pad_scanner
    import pad_pkg::*;
#(
    parameter int SETTLE = 64,
    parameter int GAP    = 100000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          multitap,
    pad_scanner_if.master pad,
    output btn_t          p1_btn,
    output btn_t          p2_btn,
    output btn_t          p3_btn,
    output btn_t          p4_btn,
    output logic [3:0]    present,
    output logic [3:0]    six_btn,
    output logic          valid,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SEL   = SEL;
    localparam logic [1:0] S_PHASE = PHASE;
    localparam logic [1:0] S_DONE  = DONE;

    // One down-counter serves both the settle time and the inter-scan gap.
    localparam int CNT_MAX = (SETTLE > GAP) ? SETTLE : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
    localparam logic [CW-1:0] GAP_LD    = CW'(GAP);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    phase;
    logic [1:0]    idx;
    logic          multi;
    logic          th;
    logic [6:0]    tap;

    // Working copy for the player currently being scanned.
    btn_t          cur_btn;
    logic          cur_present;
    logic          cur_six;

    // Shadow results, copied to the outputs only when the scan completes.
    btn_t          sh_btn [4];
    logic [3:0]    sh_present;
    logic [3:0]    sh_six;

    btn_t          dec_mask;
    btn_t          dec_val;
    logic          dec_present_we;
    logic          dec_present_val;
    logic          dec_six_we;
    logic          dec_six_val;

    // TH readback is not needed: TH is always driven by the console.
    logic          th_readback_unused;
    assign th_readback_unused = pad.port_in[PIN_TH];

    assign pad.port_out = {th, 6'b0};
    assign pad.port_dir = 7'h40;
    assign pad.tap_out  = tap;
    assign dbg_state    = state;

    pad_phase_decode u_decode (
        .phase       (phase),
        .pins        (pad.port_in[5:0]),
        .present_in  (cur_present),
        .six_in      (cur_six),
        .btn_mask    (dec_mask),
        .btn_val     (dec_val),
        .present_we  (dec_present_we),
        .present_val (dec_present_val),
        .six_we      (dec_six_we),
        .six_val     (dec_six_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            phase       <= '0;
            idx         <= '0;
            multi       <= 1'b0;
            th          <= 1'b1;
            tap         <= TAP_NONE;
            cur_btn     <= '0;
            cur_present <= 1'b0;
            cur_six     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sh_btn[i] <= '0;
            end
            sh_present  <= '0;
            sh_six      <= '0;
            p1_btn      <= '0;
            p2_btn      <= '0;
            p3_btn      <= '0;
            p4_btn      <= '0;
            present     <= '0;
            six_btn     <= '0;
            valid       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cnt == '0) begin
                        // Scan start: latch player count, clear the shadow so
                        // players that are not scanned report zeros.
                        multi       <= multitap;
                        idx         <= 2'd0;
                        tap         <= tap_select(multitap, 2'd0);
                        th          <= 1'b1;
                        cnt         <= SETTLE_LD;
                        cur_btn     <= '0;
                        cur_present <= 1'b0;
                        cur_six     <= 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            sh_btn[i] <= '0;
                        end
                        sh_present  <= '0;
                        sh_six      <= '0;
                        state       <= S_SEL;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_SEL: begin
                    if (cnt == '0) begin
                        phase <= 3'd0;
                        th    <= 1'b1;
                        cnt   <= SETTLE_LD;
                        state <= S_PHASE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_PHASE: begin
                    if (cnt == '0) begin
                        // Sample point: last cycle of the phase.
                        cur_btn <= (cur_btn & ~dec_mask) | (dec_val & dec_mask);
                        if (dec_present_we) begin
                            cur_present <= dec_present_val;
                        end
                        if (dec_six_we) begin
                            cur_six <= dec_six_val;
                        end
                        if (phase == 3'd7) begin
                            // Phase 7 never samples, so cur_* are final here.
                            th                <= 1'b1;
                            sh_btn[idx]       <= cur_present ? cur_btn : '0;
                            sh_present[idx]   <= cur_present;
                            sh_six[idx]       <= cur_present & cur_six;
                            if (multi && (idx != 2'd3)) begin
                                idx         <= idx + 2'd1;
                                tap         <= tap_select(multi, idx + 2'd1);
                                cnt         <= SETTLE_LD;
                                cur_btn     <= '0;
                                cur_present <= 1'b0;
                                cur_six     <= 1'b0;
                                state       <= S_SEL;
                            end else begin
                                tap   <= TAP_NONE;
                                state <= S_DONE;
                            end
                        end else begin
                            // Next phase p+1 drives TH = ~(p+1)[0] = p[0].
                            phase <= phase + 3'd1;
                            th    <= phase[0];
                            cnt   <= SETTLE_LD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_DONE: begin
                    p1_btn  <= sh_btn[0];
                    p2_btn  <= sh_btn[1];
                    p3_btn  <= sh_btn[2];
                    p4_btn  <= sh_btn[3];
                    present <= sh_present;
                    six_btn <= sh_six;
                    valid   <= 1'b1;
                    tap     <= TAP_NONE;
                    cnt     <= GAP_LD;
                    state   <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pad_scanner.sv
// tb_pad_scanner: directed bench for pad_scanner with a behavioural
// 3/6-button pad model behind an optional 4-way tap model.
module tb_pad_scanner;

    localparam int SETTLE = 4;
    localparam int GAP    = 50;

    logic        clk;
    logic        reset;
    logic        multitap;
    logic [11:0] p1_btn, p2_btn, p3_btn, p4_btn;
    logic [3:0]  present;
    logic [3:0]  six_btn;
    logic        valid;
    logic [1:0]  dbg_state;

    int n_tests;
    int n_fail;

    pad_scanner_if pad_bus ();

    pad_scanner #(.SETTLE(SETTLE), .GAP(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .multitap  (multitap),
        .pad       (pad_bus),
        .p1_btn    (p1_btn),
        .p2_btn    (p2_btn),
        .p3_btn    (p3_btn),
        .p4_btn    (p4_btn),
        .present   (present),
        .six_btn   (six_btn),
        .valid     (valid),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- pad model ----------------
    logic [11:0] pad_btn [4];
    logic [3:0]  pad_six;
    logic [3:0]  pad_conn;
    int          low_cnt;
    int          hi_time;
    logic        th_q;
    logic [1:0]  sel;

    // 6-button pads count TH falling edges; a long TH-high period resets it.
    always @(posedge clk) begin
        th_q <= pad_bus.port_out[6];
        if (pad_bus.port_out[6]) hi_time <= hi_time + 1;
        else hi_time <= 0;
        if (th_q && !pad_bus.port_out[6]) low_cnt <= low_cnt + 1;
        else if (pad_bus.port_out[6] && hi_time >= 16) low_cnt <= 0;
    end

    function automatic logic [6:0] pad_pins(input logic [11:0] b, input logic six,
                                            input logic th, input int lc);
        logic [3:0] d;
        logic       tl;
        logic       tr;
        if (th) begin
            tl = ~b[5];
            tr = ~b[6];
            if (six && lc == 3) d = {~b[11], ~b[8], ~b[9], ~b[10]};
            else d = {~b[0], ~b[1], ~b[2], ~b[3]};
        end else begin
            tl = ~b[4];
            tr = ~b[7];
            if (six && lc == 3) d = 4'h0;
            else if (six && lc >= 4) d = 4'hF;
            else d = {2'b00, ~b[2], ~b[3]};
        end
        return {th, tr, tl, d};
    endfunction

    always_comb begin
        sel = pad_bus.tap_out[6] ? 2'd0 : pad_bus.tap_out[5:4];
        if (pad_conn[sel])
            pad_bus.port_in = pad_pins(pad_btn[sel], pad_six[sel], pad_bus.port_out[6], low_cnt);
        else
            pad_bus.port_in = 7'h7F;
    end

    // ---------------- helpers (no checking) ----------------
    task automatic wait_valid(input int budget, output int n, output bit seen);
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                seen = 1'b1;
                n    = i;
                break;
            end
        end
    endtask

    task automatic wait_tap(input logic [6:0] v, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (pad_bus.tap_out == v) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (pad_bus.port_out !== 7'h40) begin n_fail++; $display("FAIL reset_port_out: got %h expected 40", pad_bus.port_out); end
        n_tests++; if (pad_bus.port_dir !== 7'h40) begin n_fail++; $display("FAIL reset_port_dir: got %h expected 40", pad_bus.port_dir); end
        n_tests++; if (pad_bus.tap_out !== 7'h70) begin n_fail++; $display("FAIL reset_tap_out: got %h expected 70", pad_bus.tap_out); end
        n_tests++; if ({p1_btn, p2_btn, p3_btn, p4_btn} !== 48'h0) begin n_fail++; $display("FAIL reset_btn: got %h expected 0", {p1_btn, p2_btn, p3_btn, p4_btn}); end
        n_tests++; if ({present, six_btn} !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got %h expected 00", {present, six_btn}); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_three_button();
        logic [7:0] th_seen;
        int         vn;
        bit         seen;
        pad_btn[0] = 12'h0A0;   // B + START
        pad_six[0] = 1'b0;
        th_seen    = '0;
        vn         = 0;
        seen       = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (n >= 5 && n < 37 && ((n - 5) % 4) == 0) th_seen[(n - 5) / 4] = pad_bus.port_out[6];
            if (valid) begin
                seen = 1'b1;
                vn   = n;
                break;
            end
        end
        n_tests++; if (th_seen !== 8'b0101_0101) begin n_fail++; $display("FAIL th_sequence: got %b expected 01010101 (p7..p0)", th_seen); end
        n_tests++; if (!seen || vn != 37) begin n_fail++; $display("FAIL valid_latency_1p: got %0d (seen %0d) expected 37", vn, seen); end
        n_tests++; if (p1_btn !== 12'h0A0) begin n_fail++; $display("FAIL btn_3b: got %h expected 0a0", p1_btn); end
        n_tests++; if (present !== 4'b0001) begin n_fail++; $display("FAIL present_3b: got %b expected 0001", present); end
        n_tests++; if (six_btn !== 4'b0000) begin n_fail++; $display("FAIL six_3b: got %b expected 0000", six_btn); end
        @(posedge clk); #1;
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse_width: got %b expected 0", valid); end
    endtask

    task automatic test_six_button();
        int vn;
        bit seen;
        pad_btn[0] = 12'h908;   // X + MODE + UP
        pad_six[0] = 1'b1;
        wait_valid(300, vn, seen);
        n_tests++; if (!seen) begin n_fail++; $display("FAIL valid_6b: got none expected pulse"); end
        n_tests++; if (p1_btn !== 12'h908) begin n_fail++; $display("FAIL btn_6b: got %h expected 908", p1_btn); end
        n_tests++; if (six_btn[0] !== 1'b1 || present[0] !== 1'b1) begin n_fail++; $display("FAIL flags_6b: got six %b present %b expected 1 1", six_btn[0], present[0]); end
    endtask

    task automatic test_no_pad();
        int vn;
        bit seen;
        pad_conn[0] = 1'b0;
        wait_valid(300, vn, seen);
        n_tests++; if (!seen) begin n_fail++; $display("FAIL valid_nopad: got none expected pulse"); end
        n_tests++; if (p1_btn !== 12'h000) begin n_fail++; $display("FAIL btn_nopad: got %h expected 000", p1_btn); end
        n_tests++; if ({present, six_btn} !== 8'h00) begin n_fail++; $display("FAIL flags_nopad: got %h expected 00", {present, six_btn}); end
    endtask

    task automatic test_multitap();
        logic [6:0] tap_q[$];
        logic [6:0] exp_tap [5];
        logic [6:0] prev;
        int         vn;
        bit         seen;
        bit         started;
        pad_conn   = 4'hF;
        pad_six    = 4'h0;
        pad_btn[0] = 12'h000;
        pad_btn[1] = 12'h000;
        pad_btn[2] = 12'h040;   // C on player 3
        pad_btn[3] = 12'h000;
        exp_tap[0] = 7'h00; exp_tap[1] = 7'h10; exp_tap[2] = 7'h20;
        exp_tap[3] = 7'h30; exp_tap[4] = 7'h70;
        multitap = 1'b1;
        wait_tap(7'h00, 300, started);
        n_tests++; if (!started) begin n_fail++; $display("FAIL mt_start: got no tap select expected 00"); end
        tap_q.push_back(pad_bus.tap_out);
        prev = pad_bus.tap_out;
        seen = 1'b0;
        vn   = 0;
        for (int n = 1; n < 400; n++) begin
            @(posedge clk); #1;
            if (pad_bus.tap_out !== prev) begin
                tap_q.push_back(pad_bus.tap_out);
                prev = pad_bus.tap_out;
            end
            if (valid) begin
                seen = 1'b1;
                vn   = n;
                break;
            end
        end
        n_tests++; if (tap_q.size() != 5) begin n_fail++; $display("FAIL mt_tap_count: got %0d expected 5", tap_q.size()); end
        for (int i = 0; i < 5 && i < tap_q.size(); i++) begin
            n_tests++; if (tap_q[i] !== exp_tap[i]) begin n_fail++; $display("FAIL mt_tap_step%0d: got %h expected %h", i, tap_q[i], exp_tap[i]); end
        end
        n_tests++; if (!seen || vn != 4 * 9 * SETTLE + 1) begin n_fail++; $display("FAIL mt_latency: got %0d expected %0d", vn, 4 * 9 * SETTLE + 1); end
        n_tests++; if ({p1_btn, p2_btn, p3_btn, p4_btn} !== {12'h000, 12'h000, 12'h040, 12'h000}) begin n_fail++; $display("FAIL mt_btn: got %h expected 000000040000", {p1_btn, p2_btn, p3_btn, p4_btn}); end
        n_tests++; if (present !== 4'hF || six_btn !== 4'h0) begin n_fail++; $display("FAIL mt_flags: got present %b six %b expected 1111 0000", present, six_btn); end
    endtask

    task automatic test_reset_mid_scan();
        int  vn;
        bit  seen;
        int  bad_valid;
        wait_tap(7'h10, 300, seen);
        n_tests++; if (!seen) begin n_fail++; $display("FAIL rm_reach_p2: got no player-2 select expected 10"); end
        repeat (17) @(posedge clk);
        #1;
        n_tests++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL rm_in_phase: got state %0d expected 2", dbg_state); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (pad_bus.port_out !== 7'h40 || pad_bus.tap_out !== 7'h70) begin n_fail++; $display("FAIL rm_pins: got out %h tap %h expected 40 70", pad_bus.port_out, pad_bus.tap_out); end
        n_tests++; if ({p1_btn, p2_btn, p3_btn, p4_btn, present, six_btn} !== 56'h0) begin n_fail++; $display("FAIL rm_outputs: got %h expected 0", {p1_btn, p2_btn, p3_btn, p4_btn, present, six_btn}); end
        bad_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid !== 1'b0) bad_valid++;
            @(posedge clk); #1;
        end
        n_tests++; if (bad_valid != 0) begin n_fail++; $display("FAIL rm_no_valid: got %0d pulses expected 0", bad_valid); end
        @(negedge clk);
        reset = 1'b0;
        wait_valid(400, vn, seen);
        n_tests++; if (!seen || vn != 4 * 9 * SETTLE + 1) begin n_fail++; $display("FAIL rm_fresh_scan: got %0d (seen %0d) expected %0d", vn, seen, 4 * 9 * SETTLE + 1); end
        n_tests++; if (p3_btn !== 12'h040) begin n_fail++; $display("FAIL rm_fresh_btn: got %h expected 040", p3_btn); end
    endtask

    task automatic test_multitap_toggle();
        int vn;
        bit seen;
        bit tap_moved;
        int vn2;
        bit seen2;
        bit started;
        multitap = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen      = 1'b0;
        tap_moved = 1'b0;
        vn        = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (n == 10) multitap = 1'b1;
            if (pad_bus.tap_out !== 7'h70) tap_moved = 1'b1;
            if (valid) begin
                seen = 1'b1;
                vn   = n;
                break;
            end
        end
        n_tests++; if (!seen || vn != 37) begin n_fail++; $display("FAIL tg_single_latency: got %0d (seen %0d) expected 37", vn, seen); end
        n_tests++; if (tap_moved) begin n_fail++; $display("FAIL tg_tap_idle: got tap select expected 70 throughout"); end
        n_tests++; if (present !== 4'b0001) begin n_fail++; $display("FAIL tg_present_single: got %b expected 0001", present); end
        wait_tap(7'h00, 300, started);
        n_tests++; if (!started) begin n_fail++; $display("FAIL tg_next_scan_tap: got none expected 00"); end
        wait_valid(400, vn2, seen2);
        n_tests++; if (!seen2 || present !== 4'hF) begin n_fail++; $display("FAIL tg_present_four: got %b (seen %0d) expected 1111", present, seen2); end
    endtask

    // ---------------- sequence ----------------
    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        multitap = 1'b0;
        pad_conn = 4'hF;
        pad_six  = 4'h0;
        for (int i = 0; i < 4; i++) pad_btn[i] = 12'h000;
        low_cnt  = 0;
        hi_time  = 0;
        th_q     = 1'b1;

        test_reset();
        test_three_button();
        test_six_button();
        test_no_pad();
        test_multitap();
        test_reset_mid_scan();
        test_multitap_toggle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

endmodule
